mul_issue_ctrl: RTL and testbench

Sequences and shares the single-cycle 32x32 Booth multiplier (booth32x32_top) between two requesters, e.g. the integer pipe and a coprocessor port. It performs round-robin arbitration and registers operands so the combinational multiplier runs as a fixed multicycle path. It maps the four RV32M multiply ops onto the multiplier's signed/unsigned modes, including a one-cycle high-word correction for MULHSU. It returns a tagged 32-bit result over a valid/ready response channel with backpressure.

---
 rtl/mul_pkg.sv | 26 ++
 rtl/rr_arb2.sv | 31 +++
 rtl/mul_issue_ctrl.sv | 128 ++++++++++++
 tb/tb_mul_issue_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the multiply issue controller: op encodings,
// controller state type and datapath width.
package mul_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        MUL_OP_MUL    = 2'd0,
        MUL_OP_MULH   = 2'd1,
        MUL_OP_MULHSU = 2'd2,
        MUL_OP_MULHU  = 2'd3
    } mul_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_FIXUP = 2'd2,
        ST_RESP  = 2'd3
    } mul_state_e;

    // MULHSU runs the multiplier unsigned and corrects the high word afterwards.
    function automatic logic op_is_signed(input mul_op_e op);
        return (op == MUL_OP_MUL) || (op == MUL_OP_MULH);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. On a tie the port that was not granted
// last wins; rr_last only moves when the caller strobes advance.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic rr_last;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = rr_last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last <= 1'b1;
        end else if (advance) begin
            rr_last <= grant[1];
        end
    end

endmodule

// File: rtl/mul_issue_ctrl.sv
// Shares one combinational 32x32 multiplier between two requesters, running it
// as a fixed multicycle path from registered operands and returning tagged results.
module mul_issue_ctrl
    import mul_pkg::*;
#(
    parameter int MULT_CYCLES = 2,
    parameter int TAG_W       = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 req_valid,
    output logic [1:0]                 req_ready,
    input  logic [1:0][1:0]            req_op,
    input  logic [1:0][XLEN-1:0]       req_a,
    input  logic [1:0][XLEN-1:0]       req_b,
    input  logic [1:0][TAG_W-1:0]      req_tag,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic                       rsp_port,
    output logic [TAG_W-1:0]           rsp_tag,
    output logic [XLEN-1:0]            rsp_data,
    output logic [XLEN-1:0]            mul_a,
    output logic [XLEN-1:0]            mul_b,
    output logic                       mul_signed,
    input  logic [XLEN-1:0]            mul_prod_msb,
    input  logic [XLEN-1:0]            mul_prod_lsb,
    output mul_state_e                 dbg_state
);

    localparam int CNT_W = 4;

    // Handshakes: a request transfers on an edge where req_valid[i] and
    // req_ready[i] are both high; the response transfers where rsp_valid and
    // rsp_ready are both high. Valid may not depend on ready.

    mul_state_e        state;
    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;
    mul_op_e           op_q;
    logic [TAG_W-1:0]  tag_q;
    logic              port_q;
    logic              signed_q;
    logic [XLEN-1:0]   result_q;
    logic              rsp_valid_q;

    logic [1:0]        grant;
    logic              gport;
    logic              accept;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (accept),
        .grant   (grant)
    );

    assign req_ready = (state == ST_IDLE && !rst) ? grant : 2'b00;
    assign accept    = |(req_ready & req_valid);
    assign gport     = grant[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= MUL_OP_MUL;
            tag_q       <= '0;
            port_q      <= 1'b0;
            signed_q    <= 1'b0;
            result_q    <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        a_q      <= req_a[gport];
                        b_q      <= req_b[gport];
                        op_q     <= mul_op_e'(req_op[gport]);
                        tag_q    <= req_tag[gport];
                        port_q   <= gport;
                        signed_q <= op_is_signed(mul_op_e'(req_op[gport]));
                        cnt      <= CNT_W'(MULT_CYCLES - 1);
                        state    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (cnt == '0) begin
                        result_q <= (op_q == MUL_OP_MUL) ? mul_prod_lsb : mul_prod_msb;
                        if (op_q == MUL_OP_MULHSU) begin
                            state <= ST_FIXUP;
                        end else begin
                            state       <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_FIXUP: begin
                    // Unsigned product over-counts by b*2^32 when a is negative.
                    result_q    <= result_q - (a_q[XLEN-1] ? b_q : '0);
                    state       <= ST_RESP;
                    rsp_valid_q <= 1'b1;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_port   = port_q;
    assign rsp_tag    = tag_q;
    assign rsp_data   = result_q;
    assign mul_a      = a_q;
    assign mul_b      = b_q;
    assign mul_signed = signed_q;
    assign dbg_state  = state;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench for mul_issue_ctrl with a behavioural stand-in for the
// external multiplier.
module tb_mul_issue_ctrl;
    import mul_pkg::*;

    localparam int MULT_CYCLES = 2;
    localparam int TAG_W       = 4;

    logic                  clk;
    logic                  rst;
    logic [1:0]            req_valid;
    logic [1:0]            req_ready;
    logic [1:0][1:0]       req_op;
    logic [1:0][31:0]      req_a;
    logic [1:0][31:0]      req_b;
    logic [1:0][TAG_W-1:0] req_tag;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_port;
    logic [TAG_W-1:0]      rsp_tag;
    logic [31:0]           rsp_data;
    logic [31:0]           mul_a;
    logic [31:0]           mul_b;
    logic                  mul_signed;
    logic [31:0]           mul_prod_msb;
    logic [31:0]           mul_prod_lsb;
    mul_state_e            dbg_state;

    int n_checks;
    int n_fail;

    mul_issue_ctrl #(.MULT_CYCLES(MULT_CYCLES), .TAG_W(TAG_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_tag      (req_tag),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_port     (rsp_port),
        .rsp_tag      (rsp_tag),
        .rsp_data     (rsp_data),
        .mul_a        (mul_a),
        .mul_b        (mul_b),
        .mul_signed   (mul_signed),
        .mul_prod_msb (mul_prod_msb),
        .mul_prod_lsb (mul_prod_lsb),
        .dbg_state    (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // external multiplier stand-in: sign- or zero-extend, 64-bit product
    logic [63:0] ext_a, ext_b, prod;
    always_comb begin
        ext_a = mul_signed ? {{32{mul_a[31]}}, mul_a} : {32'b0, mul_a};
        ext_b = mul_signed ? {{32{mul_b[31]}}, mul_b} : {32'b0, mul_b};
        prod  = ext_a * ext_b;
    end
    assign mul_prod_msb = prod[63:32];
    assign mul_prod_lsb = prod[31:0];

    typedef struct {
        logic        port;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
        logic [31:0] exp_data;
        int          exp_lat;
        logic        exp_signed;
    } vec_t;

    vec_t vecs[10];

    // scoreboard: {port, tag, data}
    logic [36:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_port(input logic p, input logic [1:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [3:0] tag);
        req_op[p]  = op;
        req_a[p]   = a;
        req_b[p]   = b;
        req_tag[p] = tag;
    endtask

    task automatic wait_rsp(input string name, output int lat);
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!rsp_valid) check({name, "_timeout"}, 32'(rsp_valid), 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        int lat;
        string nm;
        nm = $sformatf("vec%0d", idx);
        @(posedge clk); #1;
        rsp_ready    = 1'b1;
        req_valid    = 2'b00;
        drive_port(v.port, v.op, v.a, v.b, v.tag);
        req_valid[v.port] = 1'b1;
        #1;
        n = 0;
        while (!req_ready[v.port] && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        check({nm, "_ready"}, 32'(req_ready), 32'(2'b01 << v.port));
        @(posedge clk); #1;
        req_valid = 2'b00;
        check({nm, "_signed"}, 32'(mul_signed), 32'(v.exp_signed));
        wait_rsp(nm, lat);
        check({nm, "_latency"}, 32'(lat), 32'(v.exp_lat));
        check({nm, "_data"}, rsp_data, v.exp_data);
        check({nm, "_port"}, 32'(rsp_port), 32'(v.port));
        check({nm, "_tag"}, 32'(rsp_tag), 32'(v.tag));
        @(posedge clk); #1;
        check({nm, "_rsp_done"}, 32'(rsp_valid), 32'd0);
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({nm, "_rsp_data"}, rsp_data, 32'd0);
        check({nm, "_rsp_tag"}, 32'(rsp_tag), 32'd0);
        check({nm, "_rsp_port"}, 32'(rsp_port), 32'd0);
        check({nm, "_mul_a"}, mul_a, 32'd0);
        check({nm, "_mul_b"}, mul_b, 32'd0);
        check({nm, "_mul_signed"}, 32'(mul_signed), 32'd0);
        check({nm, "_req_ready"}, 32'(req_ready), 32'd0);
        check({nm, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
    endtask

    initial begin
        int lat;
        int cyc;
        int n_rsp;
        int n_grant;
        logic both_hi;
        logic saw_rsp;
        logic [36:0] e;
        logic [31:0] held_data;
        logic [3:0]  held_tag;
        logic [1:0]  grant_log[8];

        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        req_tag   = '0;

        vecs[0] = '{1'b0, 2'd0, 32'd7,         32'd6,         4'h3, 32'h0000002A, 2, 1'b1};
        vecs[1] = '{1'b1, 2'd1, 32'hFFFFFFFF,  32'hFFFFFFFF,  4'h5, 32'h00000000, 2, 1'b1};
        vecs[2] = '{1'b0, 2'd3, 32'hFFFFFFFF,  32'hFFFFFFFF,  4'h6, 32'hFFFFFFFE, 2, 1'b0};
        vecs[3] = '{1'b1, 2'd2, 32'hFFFFFFFF,  32'hFFFFFFFF,  4'h8, 32'hFFFFFFFF, 3, 1'b0};
        vecs[4] = '{1'b0, 2'd2, 32'h80000000,  32'd2,         4'h9, 32'hFFFFFFFF, 3, 1'b0};
        vecs[5] = '{1'b1, 2'd0, 32'hFFFFFFFF,  32'hFFFFFFFF,  4'hA, 32'h00000001, 2, 1'b1};
        vecs[6] = '{1'b0, 2'd1, 32'h80000000,  32'h80000000,  4'hB, 32'h40000000, 2, 1'b1};
        vecs[7] = '{1'b1, 2'd3, 32'h12345678,  32'h00000010,  4'hC, 32'h00000001, 2, 1'b0};
        vecs[8] = '{1'b0, 2'd2, 32'h7FFFFFFF,  32'hFFFFFFFF,  4'hD, 32'h7FFFFFFE, 3, 1'b0};
        vecs[9] = '{1'b0, 2'd2, 32'hFFFFFFFE,  32'd3,         4'hE, 32'hFFFFFFFF, 3, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // round robin with both ports requesting continuously
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        drive_port(1'b0, 2'd0, 32'd3, 32'd5, 4'hA);
        drive_port(1'b1, 2'd3, 32'hFFFFFFFF, 32'd2, 4'h5);
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back({1'b0, 4'hA, 32'd15});
            exp_q.push_back({1'b1, 4'h5, 32'd1});
        end
        rsp_ready = 1'b1;
        req_valid = 2'b11;
        #1;
        both_hi = 1'b0;
        n_rsp   = 0;
        n_grant = 0;
        cyc     = 0;
        while (n_rsp < 4 && cyc < 80) begin
            if (req_ready == 2'b11) both_hi = 1'b1;
            if (req_ready != 2'b00 && n_grant < 8) begin
                grant_log[n_grant] = req_ready;
                n_grant++;
            end
            if (rsp_valid) begin
                e = exp_q.pop_front();
                check($sformatf("rr_rsp%0d_port", n_rsp), 32'(rsp_port), 32'(e[36]));
                check($sformatf("rr_rsp%0d_tag", n_rsp), 32'(rsp_tag), 32'(e[35:32]));
                check($sformatf("rr_rsp%0d_data", n_rsp), rsp_data, e[31:0]);
                n_rsp++;
                if (n_rsp == 4) req_valid = 2'b00;
            end
            @(posedge clk); #2;
            cyc++;
        end
        check("rr_rsp_count", 32'(n_rsp), 32'd4);
        check("rr_both_ready", 32'(both_hi), 32'd0);
        check("rr_grant_count", 32'(n_grant), 32'd4);
        for (int k = 0; k < 4 && k < n_grant; k++)
            check($sformatf("rr_grant%0d", k), 32'(grant_log[k]), 32'((k % 2 == 0) ? 2'b01 : 2'b10));
        req_valid = 2'b00;

        // response backpressure
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        drive_port(1'b0, 2'd0, 32'd9, 32'd9, 4'h7);
        req_valid = 2'b01;
        #1;
        check("stall_ready0", 32'(req_ready), 32'(2'b01));
        @(posedge clk); #1;
        drive_port(1'b1, 2'd0, 32'd2, 32'd2, 4'h1);
        req_valid = 2'b10;
        wait_rsp("stall", lat);
        held_data = rsp_data;
        held_tag  = rsp_tag;
        check("stall_data", held_data, 32'd81);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check($sformatf("stall%0d_valid", k), 32'(rsp_valid), 32'd1);
            check($sformatf("stall%0d_data", k), rsp_data, 32'd81);
            check($sformatf("stall%0d_tag", k), 32'(rsp_tag), 32'h7);
            check($sformatf("stall%0d_req_ready", k), 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("release_state", 32'(dbg_state), 32'(ST_IDLE));
        check("release_valid", 32'(rsp_valid), 32'd0);
        check("release_req_ready", 32'(req_ready), 32'(2'b10));
        @(posedge clk); #1;
        req_valid = 2'b00;
        check("next_accept_state", 32'(dbg_state), 32'(ST_EXEC));
        check("next_accept_mul_a", mul_a, 32'd2);
        wait_rsp("next", lat);
        check("next_data", rsp_data, 32'd4);
        check("next_port", 32'(rsp_port), 32'd1);
        check("next_tag", 32'(rsp_tag), 32'h1);
        @(posedge clk); #1;

        // reset in the middle of an operation
        drive_port(1'b0, 2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'h9);
        req_valid = 2'b01;
        #1;
        check("abort_ready", 32'(req_ready), 32'(2'b01));
        @(posedge clk); #1;
        req_valid = 2'b00;
        check("abort_exec", 32'(dbg_state), 32'(ST_EXEC));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check_all_zero("abort");
        saw_rsp = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (rsp_valid) saw_rsp = 1'b1;
        end
        check("abort_no_rsp", 32'(saw_rsp), 32'd0);
        drive_port(1'b1, 2'd0, 32'd1, 32'd1, 4'h2);
        req_valid = 2'b11;
        #1;
        check("abort_tie_port0", 32'(req_ready), 32'(2'b01));
        req_valid = 2'b00;
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
